pwm_ctrl: RTL and testbench

Single-channel PWM controller that sits behind the SPI slave register port. It decodes the slave's 2-bit address, 8-bit write data and write-enable level into four control registers, and returns read data to the slave's read port. It double-buffers timing values and sequences the prescaler and period counter through a small run/drain state machine that drives `pwm_out`.

---
 rtl/pwm_ctrl_if.sv | 11 +
 rtl/pwm_ctrl.sv | 131 +++++++++++++
 tb/tb_pwm_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ctrl_if.sv
// Register port between the SPI slave and the PWM controller.
// The SPI slave is the master side: it drives address, write data and the write-enable level.
interface pwm_ctrl_if;
    logic [1:0] addr;
    logic [7:0] data_wr;
    logic       wr_en;
    logic [7:0] data_rd;

    modport master (output addr, data_wr, wr_en, input data_rd);
    modport slave  (input addr, data_wr, wr_en, output data_rd);
endinterface

// File: rtl/pwm_ctrl.sv
// Single-channel PWM: register decode on wr_en rising edges, double-buffered timing values,
// and a run/drain sequencer around a prescaler plus period counter.
module pwm_ctrl #(
    parameter logic [7:0] RESET_PERIOD = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    pwm_ctrl_if.slave  bus,
    output logic       pwm_out,
    output logic       period_end
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t     state, state_nxt;
    logic       wr_en_q;
    logic       ctrl_en, ctrl_inv, ctrl_os;
    logic [7:0] presc_sh, period_sh, duty_sh;
    logic [7:0] presc_act, period_act, duty_act;
    logic [7:0] presc_nxt, period_nxt, duty_nxt;
    logic [7:0] pre_cnt, cnt;

    logic commit, wr_ctrl, en_wr1, en_wr0, upd;
    logic running, tick, pend;
    logic load, os_stop;

    // A level-held wr_en produces exactly one commit, on its rising edge.
    assign commit  = bus.wr_en & ~wr_en_q;
    assign wr_ctrl = commit && (bus.addr == 2'd0);
    assign en_wr1  = wr_ctrl &&  bus.data_wr[0];
    assign en_wr0  = wr_ctrl && !bus.data_wr[0];
    assign upd     = wr_ctrl &&  bus.data_wr[3];

    assign running = (state != IDLE);
    assign tick    = running && (pre_cnt == presc_act);
    assign pend    = tick && (cnt == period_act);

    // Shadow next values; also forwarded into the active copies on a same-cycle load.
    assign presc_nxt  = (commit && bus.addr == 2'd1) ? bus.data_wr : presc_sh;
    assign period_nxt = (commit && bus.addr == 2'd2) ? bus.data_wr : period_sh;
    assign duty_nxt   = (commit && bus.addr == 2'd3) ? bus.data_wr : duty_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en_wr1) state_nxt = RUN;
            RUN: begin
                if (pend && ctrl_os) state_nxt = IDLE;
                else if (en_wr0)     state_nxt = DRAIN;
            end
            DRAIN: begin
                if (en_wr1)    state_nxt = RUN;
                else if (pend) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load    = upd || pend || (state == IDLE && state_nxt == RUN);
        os_stop = (state == RUN) && pend && ctrl_os;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q    <= 1'b0;
            ctrl_en    <= 1'b0;
            ctrl_inv   <= 1'b0;
            ctrl_os    <= 1'b0;
            presc_sh   <= 8'd0;
            period_sh  <= RESET_PERIOD;
            duty_sh    <= 8'd0;
            presc_act  <= 8'd0;
            period_act <= RESET_PERIOD;
            duty_act   <= 8'd0;
            period_end <= 1'b0;
        end else begin
            wr_en_q    <= bus.wr_en;
            period_end <= pend;
            presc_sh   <= presc_nxt;
            period_sh  <= period_nxt;
            duty_sh    <= duty_nxt;
            if (wr_ctrl) begin
                ctrl_en  <= bus.data_wr[0];
                ctrl_inv <= bus.data_wr[1];
                ctrl_os  <= bus.data_wr[2];
            end
            if (os_stop) ctrl_en <= 1'b0;
            if (load) begin
                presc_act  <= presc_nxt;
                period_act <= period_nxt;
                duty_act   <= duty_nxt;
            end
        end
    end

    // Counters sit at zero whenever the sequencer is, or is about to be, idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= 8'd0;
            cnt     <= 8'd0;
        end else if (state == IDLE || state_nxt == IDLE) begin
            pre_cnt <= 8'd0;
            cnt     <= 8'd0;
        end else if (tick) begin
            pre_cnt <= 8'd0;
            cnt     <= (cnt == period_act) ? 8'd0 : cnt + 8'd1;
        end else begin
            pre_cnt <= pre_cnt + 8'd1;
        end
    end

    assign pwm_out = ctrl_inv ^ (running && (cnt < duty_act));

    always_comb begin
        bus.data_rd = 8'd0;
        case (bus.addr)
            2'd0: bus.data_rd = {3'b000, running, 1'b0, ctrl_os, ctrl_inv, ctrl_en};
            2'd1: bus.data_rd = presc_sh;
            2'd2: bus.data_rd = period_sh;
            2'd3: bus.data_rd = duty_sh;
            default: bus.data_rd = 8'd0;
        endcase
    end

endmodule

// File: tb/tb_pwm_ctrl.sv
// Scoreboard bench for pwm_ctrl: the driver advances a time-based reference model each edge and
// queues the expected outputs; a negedge monitor pops and compares.
module tb_pwm_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic pwm_out, period_end;

    always #5 clk = ~clk;

    pwm_ctrl_if bus();

    pwm_ctrl #(.RESET_PERIOD(8'hFF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .pwm_out    (pwm_out),
        .period_end (period_end)
    );

    typedef struct {
        logic       pwm;
        logic       pe;
        logic [7:0] rd;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic rst_drv = 1'b0;

    // Reference model: position in the period is a plain cycle count t since the period began.
    int m_en, m_inv, m_os, m_presc, m_period, m_duty;
    int a_presc, a_period, a_duty;
    int m_state;  // 0 idle, 1 run, 2 drain
    int t, m_pe, m_wrq;

    function automatic void m_reset();
        m_en = 0; m_inv = 0; m_os = 0;
        m_presc = 0; m_period = 255; m_duty = 0;
        a_presc = 0; a_period = 255; a_duty = 0;
        m_state = 0; t = 0; m_pe = 0; m_wrq = 0;
    endfunction

    function automatic void m_step(input logic [1:0] a, input logic [7:0] d, input logic w);
        bit commit, wctrl, pend, go, os_old;
        int ns, len;
        commit = w && (m_wrq == 0);
        m_wrq  = w ? 1 : 0;
        len    = (a_period + 1) * (a_presc + 1);
        pend   = (m_state != 0) && (t == len - 1);
        os_old = (m_os != 0);
        wctrl  = commit && (a == 2'd0);
        go     = 0;
        ns     = m_state;
        if (commit) begin
            case (a)
                2'd0: begin m_en = int'(d[0]); m_inv = int'(d[1]); m_os = int'(d[2]); end
                2'd1: m_presc  = int'(d);
                2'd2: m_period = int'(d);
                default: m_duty = int'(d);
            endcase
        end
        case (m_state)
            0: if (wctrl && d[0]) begin ns = 1; go = 1; end
            1: if (pend && os_old) begin ns = 0; m_en = 0; end
               else if (wctrl && !d[0]) ns = 2;
            default: if (wctrl && d[0]) ns = 1;
                     else if (pend) ns = 0;
        endcase
        if (go || pend || (wctrl && d[3])) begin
            a_presc = m_presc; a_period = m_period; a_duty = m_duty;
        end
        if (ns == 0 || m_state == 0) t = 0;
        else t = pend ? 0 : t + 1;
        m_pe    = pend ? 1 : 0;
        m_state = ns;
    endfunction

    function automatic exp_t m_exp(input logic [1:0] a, input string tag);
        exp_t e;
        int run, act;
        run   = (m_state != 0) ? 1 : 0;
        act   = (run != 0 && (t / (a_presc + 1)) < a_duty) ? 1 : 0;
        e.pwm = ((m_inv ^ act) != 0);
        e.pe  = (m_pe != 0);
        case (a)
            2'd0: e.rd = 8'((run << 4) | (m_os << 2) | (m_inv << 1) | m_en);
            2'd1: e.rd = 8'(m_presc);
            2'd2: e.rd = 8'(m_period);
            default: e.rd = 8'(m_duty);
        endcase
        e.tag = tag;
        return e;
    endfunction

    // One clock: model sees the inputs held across this edge, then the next inputs are applied.
    task automatic cyc(input logic [1:0] a, input logic [7:0] d, input logic w, input string tag);
        @(posedge clk);
        if (rst_n) m_step(bus.addr, bus.data_wr, bus.wr_en);
        else       m_reset();
        #1;
        rst_n = rst_drv;
        if (!rst_drv) m_reset();
        bus.addr = a; bus.data_wr = d; bus.wr_en = w;
        exp_q.push_back(m_exp(a, tag));
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input string tag);
        cyc(a, d, 1'b1, tag);
        cyc(a, d, 1'b0, tag);
    endtask

    task automatic idle(input int n, input logic [1:0] a, input string tag);
        for (int i = 0; i < n; i++) cyc(a, 8'h00, 1'b0, tag);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, ".pwm_out"},    int'(pwm_out),     int'(e.pwm));
                chk({e.tag, ".period_end"}, int'(period_end),  int'(e.pe));
                chk({e.tag, ".data_rd"},    int'(bus.data_rd), int'(e.rd));
            end
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0;
        bus.addr = 2'd2; bus.data_wr = 8'h00; bus.wr_en = 1'b0;
        m_reset();

        // Reset state, read while held in reset.
        cyc(2'd2, 8'h00, 1'b0, "rst_period");
        cyc(2'd0, 8'h00, 1'b0, "rst_ctrl");
        cyc(2'd1, 8'h00, 1'b0, "rst_presc");
        cyc(2'd3, 8'h00, 1'b0, "rst_duty");
        rst_drv = 1'b1;
        idle(2, 2'd0, "post_rst");

        // Basic PWM: 1,1,0,0 with a period_end every 4 clocks.
        wr(2'd1, 8'd0, "wr_presc");
        wr(2'd2, 8'd3, "wr_period");
        wr(2'd3, 8'd2, "wr_duty");
        wr(2'd0, 8'h01, "wr_en");
        idle(16, 2'd0, "basic");

        // Level-held strobe with UPD: one commit only.
        for (int i = 0; i < 20; i++) cyc(2'd0, 8'h09, 1'b1, "held");
        idle(8, 2'd0, "held_after");

        // Shadow timing: DUTY rewritten mid-period only takes effect at the next period.
        wr(2'd1, 8'd1, "sh_presc");
        idle(6, 2'd3, "sh_wait");
        wr(2'd3, 8'd1, "sh_duty");
        idle(24, 2'd3, "sh_run");

        // Drain then one-shot.
        wr(2'd0, 8'h00, "drain");
        idle(12, 2'd0, "drain_run");
        wr(2'd0, 8'h05, "oneshot");
        idle(14, 2'd0, "oneshot_run");

        // Drain with INV set: output returns to the inverted idle level.
        wr(2'd0, 8'h03, "inv_run");
        idle(5, 2'd0, "inv_run");
        wr(2'd0, 8'h02, "inv_drain");
        idle(12, 2'd0, "inv_drain");

        // Reset mid-run while the inverted output is high.
        wr(2'd0, 8'h03, "rst_run");
        guard = 0;
        while (!(m_state != 0 && (m_inv ^ ((t / (a_presc + 1)) < a_duty ? 1 : 0)) != 0) && guard < 40) begin
            cyc(2'd0, 8'h00, 1'b0, "rst_wait");
            guard++;
        end
        chk("rst_wait_timeout", guard < 40 ? 1 : 0, 1);
        rst_drv = 1'b0;
        cyc(2'd0, 8'h00, 1'b0, "midrst_ctrl");
        cyc(2'd2, 8'h00, 1'b0, "midrst_period");
        cyc(2'd3, 8'h05, 1'b1, "midrst_duty");
        rst_drv = 1'b1;
        cyc(2'd3, 8'h05, 1'b1, "rel_commit");
        idle(3, 2'd3, "rel_after");

        // Randomized register traffic, UPD left clear so the timing values only move at loads.
        for (int n = 0; n < 80; n++) begin
            logic [1:0] ra;
            logic [7:0] rd;
            int hold;
            ra = 2'($urandom_range(0, 3));
            case (ra)
                2'd0: rd = 8'($urandom_range(0, 7));
                2'd1: rd = 8'($urandom_range(0, 3));
                2'd2: rd = 8'($urandom_range(0, 7));
                default: rd = 8'($urandom_range(0, 9));
            endcase
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) cyc(ra, rd, 1'b1, "rnd_wr");
            hold = $urandom_range(1, 20);
            for (int h = 0; h < hold; h++) cyc(2'($urandom_range(0, 3)), 8'($urandom), 1'b0, "rnd_idle");
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
